// File: rtl/down_counter.sv
// Programmable power-of-two down-counter that emits a one-cycle shift strobe
// at each terminal count. It is the shift-enable timebase for a downstream
// shift register or display scanner.
module down_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] sel,
  output logic       shift
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [2:0]       sel_q;
  logic [2:0]       sel_q_nxt;
  logic             armed;
  logic             armed_nxt;
  logic             shift_nxt;
  logic [WIDTH-1:0] reload_new_c;
  logic [WIDTH-1:0] reload_cur_c;
  logic             capture_c;

  // Reload values P(sel)-1 for the incoming select and the captured select
  always_comb begin
    reload_new_c = (WIDTH'(1) << sel) - WIDTH'(1);
    reload_cur_c = (WIDTH'(1) << sel_q) - WIDTH'(1);
  end

  // A load only restarts the count when idle or when the period changes
  always_comb begin
    capture_c = load && (!armed || (sel != sel_q));
  end

  // Next-state selection in priority order: capture, terminal count, decrement, hold
  always_comb begin
    cnt_nxt   = cnt;
    sel_q_nxt = sel_q;
    armed_nxt = armed;
    shift_nxt = 1'b0;
    if (capture_c) begin
      sel_q_nxt = sel;
      armed_nxt = 1'b1;
      cnt_nxt   = reload_new_c;
    end else if (armed) begin
      if (cnt == '0) begin
        shift_nxt = 1'b1;
        cnt_nxt   = reload_cur_c;
      end else begin
        cnt_nxt = cnt - WIDTH'(1);
      end
    end
  end

  // State registers; synchronous reset aborts any count and leaves the block idle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      sel_q <= 3'd0;
      armed <= 1'b0;
      shift <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      sel_q <= sel_q_nxt;
      armed <= armed_nxt;
      shift <= shift_nxt;
    end
  end

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter. The reference model tracks the number
// of edges since the last capture and predicts a strobe whenever that age is a
// multiple of the selected period.
module tb_down_counter;

  logic       clk;
  logic       rst;
  logic       load;
  logic [2:0] sel;
  logic       shift;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic m_armed = 1'b0;
  int   m_sel   = 0;
  int   m_age   = 0;
  logic exp_shift = 1'b0;

  down_counter #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .sel   (sel),
    .shift (shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, advance one edge, update the model, then settle for sampling
  task automatic tick(input logic r, input logic l, input logic [2:0] s);
    rst  = r;
    load = l;
    sel  = s;
    @(posedge clk);
    if (r) begin
      m_armed   = 1'b0;
      m_sel     = 0;
      m_age     = 0;
      exp_shift = 1'b0;
    end else if (l && (!m_armed || int'(s) != m_sel)) begin
      m_armed   = 1'b1;
      m_sel     = int'(s);
      m_age     = 0;
      exp_shift = 1'b0;
    end else if (m_armed) begin
      m_age     = m_age + 1;
      exp_shift = ((m_age % (1 << m_sel)) == 0);
    end else begin
      exp_shift = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0, 3'd0);
      checks++;
      if (shift !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got %b want 0", i, shift);
      end
    end
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 3'($urandom_range(0, 7)));
      checks++;
      if (shift !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset cyc %0d: got %b want 0", i, shift);
      end
    end
  endtask

  task automatic test_sel0();
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1, 3'd0);
      checks++;
      if (shift !== exp_shift || shift !== (i >= 1)) begin
        errors++;
        $display("FAIL sel0_continuous cyc %0d: got %b want %b", i, shift, exp_shift);
      end
    end
  endtask

  task automatic test_period4();
    int strobes = 0;
    int first   = -1;
    for (int i = 0; i < 17; i++) begin
      tick(1'b0, 1'b1, 3'd2);
      if (shift === 1'b1) begin
        strobes++;
        if (first < 0) first = i;
      end
      checks++;
      if (shift !== exp_shift) begin
        errors++;
        $display("FAIL period4 cyc %0d: got %b want %b", i, shift, exp_shift);
      end
    end
    checks++;
    if (strobes != 4 || first != 4) begin
      errors++;
      $display("FAIL period4_count: got %0d strobes first@%0d want 4 first@4", strobes, first);
    end
  endtask

  task automatic test_sel_change();
    int strobes = 0;
    tick(1'b0, 1'b1, 3'd1);
    tick(1'b0, 1'b1, 3'd1);
    // This edge would have been a terminal count under period 2
    tick(1'b0, 1'b1, 3'd2);
    checks++;
    if (shift !== 1'b0 || exp_shift !== 1'b0) begin
      errors++;
      $display("FAIL sel_change_edge: got %b want 0", shift);
    end
    for (int i = 1; i <= 12; i++) begin
      tick(1'b0, 1'b0, 3'((i % 2) ? 5 : 0));
      if (shift === 1'b1) strobes++;
      checks++;
      if (shift !== exp_shift || shift !== ((i % 4) == 0)) begin
        errors++;
        $display("FAIL sel_change_period cyc %0d: got %b want %b", i, shift, exp_shift);
      end
    end
    checks++;
    if (strobes != 3) begin
      errors++;
      $display("FAIL sel_change_count: got %0d want 3", strobes);
    end
  endtask

  task automatic test_sel7();
    int strobes = 0;
    tick(1'b0, 1'b1, 3'd7);
    for (int i = 1; i <= 384; i++) begin
      tick(1'b0, 1'b1, 3'd7);
      if (shift === 1'b1) strobes++;
      if (shift !== exp_shift) begin
        checks++;
        errors++;
        $display("FAIL sel7 cyc %0d: got %b want %b", i, shift, exp_shift);
      end
    end
    checks++;
    if (strobes != 3) begin
      errors++;
      $display("FAIL sel7_count: got %0d want 3", strobes);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b0, 1'b1, 3'd2);
    tick(1'b0, 1'b1, 3'd2);
    tick(1'b1, 1'b1, 3'd2);
    checks++;
    if (shift !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got %b want 0", shift);
    end
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b0, 3'd2);
      checks++;
      if (shift !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_mid_reset cyc %0d: got %b want 0", i, shift);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
           3'($urandom_range(0, 3)));
      checks++;
      if (shift !== exp_shift) begin
        errors++;
        $display("FAIL random cyc %0d: got %b want %b", i, shift, exp_shift);
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    sel  = 3'd0;
    test_reset();
    test_sel0();
    test_period4();
    test_sel_change();
    test_sel7();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
